// File: rtl/bpsk_symbol_framer.sv
// rtl/bpsk_symbol_framer.sv - codeword FIFO and MSB-first BPSK symbol serialiser
//
// Purpose:
//   Accepts Hamming codewords over a valid/ready handshake into a small FIFO.
//   Each codeword is then sent to the BPSK modulator as DATA_WIDTH symbols,
//   MSB first. Each symbol bit is held for CLKS_PER_SYMBOL clocks.
//   Words queued behind the current one follow it with no gap clock.
//
// Optional feature (macro BPSK_FRAMER_PREAMBLE_EN):
//   When the macro is defined, an 8-bit PREAMBLE pattern is sent first.
//   This happens only on a start from idle, never between back-to-back words.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   in_data     in   codeword from encoder (DATA_WIDTH bits)
//   in_valid    in   in_data valid
//   in_ready    out  FIFO can accept a word (not full)
//   sym_bit     out  current symbol bit (1 -> 0 deg, 0 -> 180 deg)
//   sym_strobe  out  one-clock pulse on the first clock of every symbol
//   tx_en       out  modulator enable, high while any symbol is being sent
//   fifo_level  out  number of stored codewords

module bpsk_symbol_framer #(
    parameter int          DATA_WIDTH      = 12,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          CLKS_PER_SYMBOL = 256,
    parameter logic [7:0]  PREAMBLE        = 8'hAA
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            sym_bit,
    output logic                            sym_strobe,
    output logic                            tx_en,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int SCW = $clog2(CLKS_PER_SYMBOL);
    localparam int BCW = $clog2(DATA_WIDTH);

    localparam logic [LW-1:0]  LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [SCW-1:0] SYM_LAST = SCW'(CLKS_PER_SYMBOL - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

`ifdef BPSK_FRAMER_PREAMBLE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PRE   = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;
`endif

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------
    // Codeword FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    // Only a not-full FIFO accepts, even if a pop frees a slot on the same edge.
    assign w_push     = in_valid & ~w_full;
    assign w_rd_data  = r_mem[r_rd_ptr];
    assign in_ready   = ~w_full;
    assign fifo_level = r_level;

    // Storage is written only on an accepted push, so X on an idle bus never lands here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Symbol timing and shift register
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_shift;
    logic [SCW-1:0]        r_sym_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic                  w_sym_last;
    logic                  w_word_done;

    assign w_sym_last  = (r_sym_cnt == SYM_LAST);
    assign w_word_done = (r_state == S_SHIFT) && w_sym_last && (r_bit_cnt == BIT_LAST);

`ifdef BPSK_FRAMER_PREAMBLE_EN
    logic [7:0] r_pre_shift;
    logic [2:0] r_pre_cnt;
    logic       w_pre_done;

    assign w_pre_done = (r_state == S_PRE) && w_sym_last && (r_pre_cnt == 3'd7);

    // The preamble pattern is reloaded while idle and shifted once per symbol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_shift <= '0;
            r_pre_cnt   <= '0;
        end else if (r_state == S_IDLE) begin
            r_pre_shift <= PREAMBLE;
            r_pre_cnt   <= '0;
        end else if ((r_state == S_PRE) && w_sym_last) begin
            r_pre_shift <= {r_pre_shift[6:0], 1'b0};
            r_pre_cnt   <= r_pre_cnt + 3'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_sym_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            // Held at zero while idle, so the first clock after a load is symbol clock 0.
            if ((r_state == S_IDLE) || w_sym_last) begin
                r_sym_cnt <= '0;
            end else begin
                r_sym_cnt <= r_sym_cnt + SCW'(1);
            end

            // The codeword stays parked in r_shift during a preamble; it only shifts in SHIFT.
            if (w_pop) begin
                r_shift   <= w_rd_data;
                r_bit_cnt <= '0;
            end else if ((r_state == S_SHIFT) && w_sym_last) begin
                r_shift   <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        tx_en        = 1'b0;
        sym_bit      = 1'b0;
        sym_strobe   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
`ifdef BPSK_FRAMER_PREAMBLE_EN
                    w_next_state = S_PRE;
`else
                    w_next_state = S_SHIFT;
`endif
                end
            end
            S_SHIFT: begin
                tx_en      = 1'b1;
                sym_bit    = r_shift[DATA_WIDTH-1];
                sym_strobe = (r_sym_cnt == '0);
                if (w_word_done) begin
                    // A queued word follows on the same edge with no gap clock.
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
`ifdef BPSK_FRAMER_PREAMBLE_EN
            S_PRE: begin
                tx_en      = 1'b1;
                sym_bit    = r_pre_shift[7];
                sym_strobe = (r_sym_cnt == '0);
                if (w_pre_done) begin
                    w_next_state = S_SHIFT;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule
